// File: rtl/rida_imm_pkg.sv
// Shared widths, immediate limits and the buffered entry type for rida_imm_packer.
package rida_imm_pkg;

    localparam int unsigned IMM_W   = 14;
    localparam int unsigned HDR_W   = 18;
    localparam int unsigned INSTR_W = HDR_W + IMM_W;
    localparam int unsigned UPPER_W = INSTR_W - IMM_W + 1;

    localparam logic [IMM_W-1:0] IMM_MAX = 14'h1FFF;
    localparam logic [IMM_W-1:0] IMM_MIN = 14'h2000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               ovf;
    } imm_entry_t;

    // True when the value survives sign extension from the immediate field.
    function automatic logic imm_fits(input logic [INSTR_W-1:0] value);
        logic [UPPER_W-1:0] upper;
        upper = value[INSTR_W-1:IMM_W-1];
        return (&upper) || (~|upper);
    endfunction

endpackage

// File: rtl/rida_imm_fifo.sv
// In-order DEPTH-entry FIFO of imm_entry_t; push is ignored when full, pop when empty.
module rida_imm_fifo
    import rida_imm_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  imm_entry_t wr_data,
    input  logic       pop,
    output imm_entry_t rd_data_c,
    output logic       full_c,
    output logic       empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    imm_entry_t     mem_q [DEPTH];
    imm_entry_t     mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           do_push, do_pop;

    assign full_c    = (cnt_q == CW'(DEPTH));
    assign empty_c   = (cnt_q == '0);
    assign rd_data_c = mem_q[rd_ptr_q];
    assign do_push   = push && !full_c;
    assign do_pop    = pop && !empty_c;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/rida_imm_packer.sv
// Packs {hdr, 14-bit imm} instruction words behind a small FIFO and counts overflowing values.
// Define IMM_SAT_EN to saturate non-fitting values instead of truncating them.
module rida_imm_packer
    import rida_imm_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [HDR_W-1:0]   in_hdr,
    input  logic [INSTR_W-1:0] in_value,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_ovf,
    input  logic               clr_count,
    output logic [CNT_W-1:0]   ovf_count
);

    logic             fits_c;
    logic [IMM_W-1:0] imm_c;
    imm_entry_t       push_entry_c;
    imm_entry_t       head_c;
    logic             full_c, empty_c;
    logic             push_c, pop_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        fits_c = imm_fits(in_value);
        imm_c  = in_value[IMM_W-1:0];
`ifdef IMM_SAT_EN
        if (!fits_c) begin
            imm_c = in_value[INSTR_W-1] ? IMM_MIN : IMM_MAX;
        end
`endif
        push_entry_c.instr = {in_hdr, imm_c};
        push_entry_c.ovf   = !fits_c;
    end

    // Held low through reset so nothing is accepted before the buffer is cleared.
    assign in_ready  = rst_n && !full_c;
    assign push_c    = in_valid && in_ready;
    assign out_valid = !empty_c;
    assign pop_c     = out_valid && out_ready;
    assign out_instr = head_c.instr;
    assign out_ovf   = head_c.ovf;
    assign ovf_count = cnt_q;

    rida_imm_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .wr_data   (push_entry_c),
        .pop       (pop_c),
        .rd_data_c (head_c),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );

    // Saturating overflow counter; clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (push_c && push_entry_c.ovf && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rida_imm_packer.sv
// Directed self-checking bench for rida_imm_packer (expected values follow IMM_SAT_EN).
module tb_rida_imm_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_hdr;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_ovf;
    logic        clr_count;
    logic [7:0]  ovf_count;

    int nv   = 0;
    int nerr = 0;

    rida_imm_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_hdr    (in_hdr),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_ovf   (out_ovf),
        .clr_count (clr_count),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_hdr = '0; in_value = '0;
        out_ready = 1'b0; clr_count = 1'b0;
        tick(); tick();
        nv++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        nv++; if (out_instr !== 32'h0) begin nerr++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
        nv++; if (out_ovf !== 1'b0) begin nerr++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
        nv++; if (ovf_count !== 8'd0) begin nerr++; $display("FAIL reset_ovf_count got %0d want 0", ovf_count); end
        nv++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        rst_n = 1'b1;
        #1;
        nv++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_fit_max();
        in_valid = 1'b1; in_hdr = 18'h5; in_value = 32'h0000_1FFF;
        tick();
        in_valid = 1'b0;
        nv++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL fit_max_valid got %b want 1", out_valid); end
        nv++; if (out_instr !== 32'h0001_5FFF) begin nerr++; $display("FAIL fit_max_instr got %h want 00015fff", out_instr); end
        nv++; if (out_ovf !== 1'b0) begin nerr++; $display("FAIL fit_max_ovf got %b want 0", out_ovf); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        nv++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL fit_max_drain got %b want 0", out_valid); end
    endtask

    task automatic test_fit_min();
        logic signed [13:0] imm;
        logic [31:0]        sext;
        in_valid = 1'b1; in_hdr = 18'h5; in_value = 32'hFFFF_E000;
        tick();
        in_valid = 1'b0;
        imm  = out_instr[13:0];
        sext = 32'(imm);
        nv++; if (out_instr !== 32'h0001_6000) begin nerr++; $display("FAIL fit_min_instr got %h want 00016000", out_instr); end
        nv++; if (out_ovf !== 1'b0) begin nerr++; $display("FAIL fit_min_ovf got %b want 0", out_ovf); end
        nv++; if (sext !== 32'hFFFF_E000) begin nerr++; $display("FAIL fit_min_roundtrip got %h want ffffe000", sext); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pos, exp_neg;
`ifdef IMM_SAT_EN
        exp_pos = 32'h0001_5FFF;
        exp_neg = 32'h0001_6000;
`else
        exp_pos = 32'h0001_6000;
        exp_neg = 32'h0001_5FFF;
`endif
        in_valid = 1'b1; in_hdr = 18'h5; in_value = 32'h0000_2000;
        tick();
        in_valid = 1'b0;
        nv++; if (out_instr !== exp_pos) begin nerr++; $display("FAIL ovf_pos_instr got %h want %h", out_instr, exp_pos); end
        nv++; if (out_ovf !== 1'b1) begin nerr++; $display("FAIL ovf_pos_flag got %b want 1", out_ovf); end
        nv++; if (ovf_count !== 8'd1) begin nerr++; $display("FAIL ovf_pos_count got %0d want 1", ovf_count); end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1; in_value = 32'hFFFF_DFFF;
        tick();
        in_valid = 1'b0;
        nv++; if (out_instr !== exp_neg) begin nerr++; $display("FAIL ovf_neg_instr got %h want %h", out_instr, exp_neg); end
        nv++; if (out_ovf !== 1'b1) begin nerr++; $display("FAIL ovf_neg_flag got %b want 1", out_ovf); end
        nv++; if (ovf_count !== 8'd2) begin nerr++; $display("FAIL ovf_neg_count got %0d want 2", ovf_count); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'd100};
        logic [31:0] exps [4] = '{32'h0000_4000, 32'h0000_8001, 32'h0000_FFFF, 32'h0001_0064};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_hdr = 18'(i + 1); in_value = vals[i];
            tick();
            nv++; if (out_instr !== exps[i] || out_valid !== 1'b1)
                begin nerr++; $display("FAIL b2b_word%0d got %h/%b want %h/1", i, out_instr, out_valid, exps[i]); end
            nv++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready%0d got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        nv++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL b2b_drain got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_hdr = 18'h1; in_value = 32'd1;
        tick();
        in_hdr = 18'h2; in_value = 32'd2;
        tick();
        in_hdr = 18'h3; in_value = 32'd3;
        nv++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_full got %b want 0", in_ready); end
        tick(); tick();
        nv++; if (out_instr !== 32'h0000_4001 || out_valid !== 1'b1)
            begin nerr++; $display("FAIL bp_stall_head got %h/%b want 00004001/1", out_instr, out_valid); end
        nv++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_c_held got %b want 0", in_ready); end
        out_ready = 1'b1;
        tick();
        nv++; if (out_instr !== 32'h0000_8002) begin nerr++; $display("FAIL bp_second got %h want 00008002", out_instr); end
        tick();
        in_valid = 1'b0;
        nv++; if (out_instr !== 32'h0000_C003 || out_valid !== 1'b1)
            begin nerr++; $display("FAIL bp_third got %h/%b want 0000c003/1", out_instr, out_valid); end
        tick();
        nv++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_drain got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_counter();
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        nv++; if (ovf_count !== 8'd0) begin nerr++; $display("FAIL cnt_clear got %0d want 0", ovf_count); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_hdr = 18'h7; in_value = 32'h4000_0000;
        for (int i = 0; i < 300; i++) tick();
        nv++; if (ovf_count !== 8'd255) begin nerr++; $display("FAIL cnt_saturate got %0d want 255", ovf_count); end
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        nv++; if (ovf_count !== 8'd0) begin nerr++; $display("FAIL cnt_clr_priority got %0d want 0", ovf_count); end
        tick();
        in_valid = 1'b0;
        nv++; if (ovf_count !== 8'd1) begin nerr++; $display("FAIL cnt_after_clr got %0d want 1", ovf_count); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_hdr = 18'h7; in_value = 32'd7;
        tick();
        in_hdr = 18'h8; in_value = 32'd8;
        tick();
        in_valid = 1'b0;
        nv++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            begin nerr++; $display("FAIL rm_filled got %b/%b want 1/0", out_valid, in_ready); end
        rst_n = 1'b0;
        #1;
        nv++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rm_async_valid got %b want 0", out_valid); end
        nv++; if (ovf_count !== 8'd0) begin nerr++; $display("FAIL rm_count got %0d want 0", ovf_count); end
        tick();
        rst_n = 1'b1;
        #1;
        nv++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rm_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        tick();
        nv++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rm_stale got %b want 0", out_valid); end
        out_ready = 1'b0;
        in_valid = 1'b1; in_hdr = 18'h9; in_value = 32'd9;
        tick();
        in_valid = 1'b0;
        nv++; if (out_instr !== 32'h0002_4009 || out_valid !== 1'b1)
            begin nerr++; $display("FAIL rm_new_word got %h/%b want 00024009/1", out_instr, out_valid); end
    endtask

    initial begin
        test_reset();
        test_fit_max();
        test_fit_min();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_counter();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
        $finish;
    end

endmodule
